// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
// Command-driven controller for a 4-bit universal shift register. Accepts one
// command (load, shift right, shift left, rotate right) over valid/ready and
// sequences the register's mode selects, parallel word and serial fill bits,
// then pulses done (or aborted when cancelled).
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] reg_q,
    output logic             S0,
    output logic             S1,
    output logic [WIDTH-1:0] par_out,
    output logic             msb_in,
    output logic             lsb_in,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_ROR  = 2'b11
    } op_t;

    // Register mode encoding as seen on {S0,S1}.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t           state, state_n;
    logic [1:0]       mode, mode_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] par_n;
    op_t              op_q, op_n;
    logic             fill_q, fill_n;

    // Only reg_q[0] feeds the rotate path; the upper bits are monitored nowhere.
    logic unused_q;
    assign unused_q = ^reg_q[WIDTH-1:1];

    assign cmd_ready = (state == IDLE) & ~clear;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign aborted   = (state == ABORT);
    assign {S0, S1}  = mode;

    // State and datapath registers; clear drops any command and holds the register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            mode    <= MODE_HOLD;
            cnt     <= '0;
            par_out <= '0;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state   <= state_n;
            mode    <= mode_n;
            cnt     <= cnt_n;
            par_out <= par_n;
            op_q    <= op_n;
            fill_q  <= fill_n;
        end
    end

    // Next-state and next-datapath decode; abort overrides completion.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_n = state;
        mode_n  = mode;
        cnt_n   = cnt;
        par_n   = par_out;
        op_n    = op_q;
        fill_n  = fill_q;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (op_t'(cmd_op) == OP_LOAD) begin
                        state_n = LOAD;
                        par_n   = cmd_data;
                        mode_n  = MODE_LOAD;
                    end else begin
                        op_n   = op_t'(cmd_op);
                        fill_n = cmd_fill;
                        if (cmd_count != '0) begin
                            state_n = SHIFT;
                            cnt_n   = cmd_count;
                            mode_n  = (op_t'(cmd_op) == OP_SHL) ? MODE_SHL : MODE_SHR;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
            end
            LOAD: begin
                state_n = DONE;
                mode_n  = MODE_HOLD;
            end
            SHIFT: begin
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                    mode_n  = MODE_HOLD;
                end
            end
            DONE:    state_n = IDLE;
            ABORT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && abort) begin
            state_n = ABORT;
            mode_n  = MODE_HOLD;
        end
    end

    // Serial inputs: only live while shifting; rotate wraps the LSB back in.
    always_comb begin
        msb_in = 1'b0;
        lsb_in = 1'b0;
        if (state == SHIFT) begin
            case (op_q)
                OP_SHR:  msb_in = fill_q;
                OP_ROR:  msb_in = reg_q[0];
                OP_SHL:  lsb_in = fill_q;
                default: ;
            endcase
        end
    end

endmodule
